// File: rtl/tape_pulse_gen.sv
// Tape read-pulse generator: a FIFO of pulse lengths feeding a down-counter
// phase sequencer that drives a registered pwm output.
//
// state | meaning
// IDLE  | no pulse running; pwm holds its last level
// PH1   | first half-period (HALF_MODE=1) or one edge-to-edge phase (HALF_MODE=0)
// PH2   | second half-period, HALF_MODE=1 only
`timescale 1ns/1ps
module tape_pulse_gen #(
  parameter int TW        = 24,
  parameter int DEPTH     = 4,
  parameter bit HALF_MODE = 1'b1,
  parameter bit START_POL = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [TW-1:0]            time_val,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic                     motor_control,
  input  logic                     flush,
  output logic                     pwm,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, PH1, PH2} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [TW-1:0]   head, eff_len, half_len, rest_len;
  logic [TW-1:0]   cnt, cnt_nxt, cur_len, cur_nxt;
  logic            arm, arm_nxt, pwm_nxt, und_nxt;
  logic            wr_en, pop, empty, last;

  assign empty      = (level == '0);
  assign load_ready = (level != LW'(DEPTH));
  assign wr_en      = load_valid && load_ready && !flush;
  assign busy       = (state != IDLE);
  assign head       = mem[rd_ptr];
  assign last       = (cnt <= TW'(1));

  always_comb begin
    eff_len = head;
    if (HALF_MODE) begin
      if (head < TW'(2)) eff_len = TW'(2);
    end else begin
      if (head == '0) eff_len = TW'(1);
    end
  end

  assign half_len = eff_len >> 1;
  assign rest_len = cur_len - (cur_len >> 1);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= time_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // An entry popped from IDLE is staged in cur_len (arm) for one cycle, so
  // PH1 begins on the edge after the pop.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cur_nxt   = cur_len;
    arm_nxt   = arm;
    pwm_nxt   = pwm;
    und_nxt   = underrun;
    pop       = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      arm_nxt   = 1'b0;
      pwm_nxt   = START_POL;
      und_nxt   = 1'b0;
    end else if (!motor_control) begin
      unique case (state)
        IDLE: begin
          if (arm) begin
            state_nxt = PH1;
            arm_nxt   = 1'b0;
            cnt_nxt   = HALF_MODE ? (cur_len >> 1) : cur_len;
            pwm_nxt   = HALF_MODE ? ~START_POL : ~pwm;
          end else if (!empty) begin
            pop     = 1'b1;
            cur_nxt = eff_len;
            arm_nxt = 1'b1;
          end
        end
        PH1: begin
          if (!last) begin
            cnt_nxt = cnt - TW'(1);
          end else if (HALF_MODE) begin
            state_nxt = PH2;
            cnt_nxt   = rest_len;
            pwm_nxt   = START_POL;
          end else if (!empty) begin
            pop     = 1'b1;
            cur_nxt = eff_len;
            cnt_nxt = eff_len;
            pwm_nxt = ~pwm;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            und_nxt   = 1'b1;
          end
        end
        PH2: begin
          if (!last) begin
            cnt_nxt = cnt - TW'(1);
          end else if (!empty) begin
            pop       = 1'b1;
            state_nxt = PH1;
            cur_nxt   = eff_len;
            cnt_nxt   = half_len;
            pwm_nxt   = ~START_POL;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            und_nxt   = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_len  <= '0;
      arm      <= 1'b0;
      pwm      <= START_POL;
      underrun <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cur_len  <= cur_nxt;
      arm      <= arm_nxt;
      pwm      <= pwm_nxt;
      underrun <= und_nxt;
    end
  end

endmodule

// File: tb/tb_tape_pulse_gen.sv
// Directed bench for tape_pulse_gen: a per-cycle vector table for a single
// pulse, then hand-written sequences for queueing, full FIFO, motor stop,
// flush, length clamp, HALF_MODE=0 and reset mid-pulse.
`timescale 1ns/1ps
module tb_tape_pulse_gen;

  localparam int TW = 24;
  localparam int LW = 3;

  typedef struct {
    logic          lv;
    logic [TW-1:0] tv;
    logic          mo;
    logic          fl;
    logic          e_pwm;
    logic          e_busy;
    logic [LW-1:0] e_level;
    logic          e_ready;
    logic          e_und;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [TW-1:0] time_val;
  logic          load_valid, motor_control, flush;
  logic          load_ready, pwm, underrun, busy;
  logic [LW-1:0] level;
  logic          load_ready0, pwm0, underrun0, busy0;
  logic [LW-1:0] level0;

  int   checks = 0;
  int   errors = 0;
  bit   exp_w[$];
  vec_t vt[14];

  tape_pulse_gen #(.TW(TW), .DEPTH(4), .HALF_MODE(1'b1), .START_POL(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .time_val(time_val), .load_valid(load_valid),
    .load_ready(load_ready), .motor_control(motor_control), .flush(flush),
    .pwm(pwm), .underrun(underrun), .level(level), .busy(busy)
  );

  tape_pulse_gen #(.TW(TW), .DEPTH(4), .HALF_MODE(1'b0), .START_POL(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .time_val(time_val), .load_valid(load_valid),
    .load_ready(load_ready0), .motor_control(motor_control), .flush(flush),
    .pwm(pwm0), .underrun(underrun0), .level(level0), .busy(busy0)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lv, input logic [TW-1:0] tv, input logic mo, input logic fl);
    load_valid    = lv;
    time_val      = tv;
    motor_control = mo;
    flush         = fl;
  endtask

  function automatic vec_t mk(input logic lv, input logic [TW-1:0] tv, input logic mo,
                              input logic fl, input logic p, input logic b,
                              input logic [LW-1:0] l, input logic r, input logic u);
    vec_t v;
    v.lv = lv; v.tv = tv; v.mo = mo; v.fl = fl;
    v.e_pwm = p; v.e_busy = b; v.e_level = l; v.e_ready = r; v.e_und = u;
    return v;
  endfunction

  function automatic void add_pulse(input int t);
    int e;
    e = (t < 2) ? 2 : t;
    for (int i = 0; i < (e >> 1); i++) exp_w.push_back(1'b0);
    for (int i = 0; i < e - (e >> 1); i++) exp_w.push_back(1'b1);
  endfunction

  initial begin
    int lens_b[3];
    int vals_c[5];
    bit w0[11];
    int peak;

    // single T=10 pulse, one row per edge, then a flush
    vt[0] = mk(1'b1, TW'(10), 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0);
    vt[1] = mk(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    for (int i = 2; i <= 6; i++)  vt[i] = mk(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0);
    for (int i = 7; i <= 11; i++) vt[i] = mk(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
    vt[12] = mk(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1);
    vt[13] = mk(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    lens_b = '{6, 8, 4};
    vals_c = '{2, 4, 6, 8, 10};
    w0     = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    drive(1'b0, '0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #2;
    chk("rst_pwm", pwm, 1);
    chk("rst_level", level, 0);
    chk("rst_ready", load_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_und", underrun, 0);
    #9 rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(vt[i].lv, vt[i].tv, vt[i].mo, vt[i].fl);
      step();
      chk($sformatf("tbl%0d_pwm", i), pwm, vt[i].e_pwm);
      chk($sformatf("tbl%0d_busy", i), busy, vt[i].e_busy);
      chk($sformatf("tbl%0d_level", i), level, vt[i].e_level);
      chk($sformatf("tbl%0d_ready", i), load_ready, vt[i].e_ready);
      chk($sformatf("tbl%0d_und", i), underrun, vt[i].e_und);
    end

    // queued 6, 8, 4 back to back
    exp_w.delete();
    exp_w.push_back(1'b1); exp_w.push_back(1'b1);
    foreach (lens_b[k]) add_pulse(lens_b[k]);
    peak = 0;
    for (int e = 0; e <= 20; e++) begin
      if (e < 3) drive(1'b1, TW'(lens_b[e]), 1'b0, 1'b0);
      else       drive(1'b0, '0, 1'b0, 1'b0);
      step();
      chk($sformatf("B_pwm%0d", e), pwm, (e < exp_w.size()) ? exp_w[e] : 1'b1);
      if (int'(level) > peak) peak = int'(level);
      if (e == 19) chk("B_und_before", underrun, 0);
      if (e == 20) begin
        chk("B_und_after", underrun, 1);
        chk("B_busy_end", busy, 0);
      end
    end
    chk("B_peak", peak, 2);

    // full FIFO under motor stop; pointers wrap, 5th write dropped
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, TW'(vals_c[i]), 1'b1, 1'b0);
      step();
      chk($sformatf("C_level%0d", i), level, (i < 4) ? i + 1 : 4);
      chk($sformatf("C_ready%0d", i), load_ready, (i < 3) ? 1 : 0);
    end
    chk("C_busy_stopped", busy, 0);
    chk("C_pwm_stopped", pwm, 1);
    exp_w.delete();
    exp_w.push_back(1'b1);
    for (int i = 0; i < 4; i++) add_pulse(vals_c[i]);
    for (int e = 0; e <= 22; e++) begin
      drive(1'b0, '0, 1'b0, 1'b0);
      step();
      chk($sformatf("C_pwm%0d", e), pwm, (e < exp_w.size()) ? exp_w[e] : 1'b1);
      if (e == 0) chk("C_level_pop", level, 3);
      if (e == 22) begin
        chk("C_busy_end", busy, 0);
        chk("C_level_end", level, 0);
      end
    end

    // motor stop for 7 cycles from the 3rd PH1 cycle of T=20, write 2 meanwhile
    drive(1'b0, '0, 1'b0, 1'b1);
    step();
    chk("D_flush_und", underrun, 0);
    exp_w.delete();
    exp_w.push_back(1'b1); exp_w.push_back(1'b1);
    for (int i = 0; i < 17; i++) exp_w.push_back(1'b0);
    for (int i = 0; i < 10; i++) exp_w.push_back(1'b1);
    exp_w.push_back(1'b0); exp_w.push_back(1'b1);
    for (int e = 0; e <= 32; e++) begin
      drive((e == 0 || e == 6), TW'((e == 0) ? 20 : 2), (e >= 5 && e <= 11), 1'b0);
      step();
      chk($sformatf("D_pwm%0d", e), pwm, (e < exp_w.size()) ? exp_w[e] : 1'b1);
      if (e == 10) chk("D_level_stopped", level, 1);
      if (e == 31) chk("D_busy_end", busy, 0);
      if (e == 32) chk("D_und_end", underrun, 1);
    end

    // flush with write and motor mid-PH1
    drive(1'b0, '0, 1'b0, 1'b1);
    step();
    drive(1'b1, TW'(10), 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (3) step();
    chk("E_pwm_ph1", pwm, 0);
    chk("E_busy_ph1", busy, 1);
    drive(1'b1, TW'(7), 1'b1, 1'b1);
    step();
    chk("E_level_fl", level, 0);
    chk("E_pwm_fl", pwm, 1);
    chk("E_busy_fl", busy, 0);
    chk("E_ready_fl", load_ready, 1);
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    step();
    chk("E_level_after", level, 0);
    chk("E_busy_after", busy, 0);
    chk("E_pwm_after", pwm, 1);

    // clamp: T=0 then T=1, each a 2-cycle period, no gap
    exp_w.delete();
    exp_w.push_back(1'b1); exp_w.push_back(1'b1);
    add_pulse(0);
    add_pulse(1);
    for (int e = 0; e <= 6; e++) begin
      drive((e < 2), TW'((e == 0) ? 0 : 1), 1'b0, 1'b0);
      step();
      chk($sformatf("E_clamp_pwm%0d", e), pwm, (e < exp_w.size()) ? exp_w[e] : 1'b1);
      if (e == 6) chk("E_clamp_busy", busy, 0);
    end

    // HALF_MODE=0 instance: toggles per entry, holds level when dry
    drive(1'b0, '0, 1'b0, 1'b1);
    step();
    for (int e = 0; e <= 10; e++) begin
      drive((e < 3), TW'((e == 0) ? 3 : 2), 1'b0, 1'b0);
      step();
      chk($sformatf("F_pwm%0d", e), pwm0, w0[e]);
      if (e == 8) chk("F_und_before", underrun0, 0);
      if (e == 9) begin
        chk("F_busy_end", busy0, 0);
        chk("F_und_after", underrun0, 1);
      end
    end

    // reset asserted during PH2 with 3 entries queued
    drive(1'b0, '0, 1'b0, 1'b1);
    step();
    for (int e = 0; e <= 8; e++) begin
      drive((e < 4), TW'(10), 1'b0, 1'b0);
      step();
    end
    chk("G_pre_busy", busy, 1);
    chk("G_pre_pwm", pwm, 1);
    chk("G_pre_level", level, 3);
    rst_n = 1'b0;
    #1;
    chk("G_rst_pwm", pwm, 1);
    chk("G_rst_level", level, 0);
    chk("G_rst_busy", busy, 0);
    chk("G_rst_ready", load_ready, 1);
    chk("G_rst_und", underrun, 0);
    step();
    step();
    chk("G_rst_hold_busy", busy, 0);
    #3 rst_n = 1'b1;
    for (int e = 0; e < 20; e++) begin
      step();
      chk($sformatf("G_post_pwm%0d", e), pwm, 1);
      chk($sformatf("G_post_busy%0d", e), busy, 0);
      chk($sformatf("G_post_level%0d", e), level, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
